pic_lite_core: RTL
==================

// Module: pic_lite_core
// PURPOSE
// Parametrised accumulator CPU core executing a 14-bit PIC-style subset: literal ALU ops, byte-oriented file-register ops, GOTO and DECFSZ/INCFSZ skips.
// Fetches from an external async program ROM, holds W, STATUS (Z,C) and an internal data register file.
// Top-level compute engine of the DE0_CV design; drives LEDs/7-seg from w_q.
// PARAMETERS
// DATA_W      8   datapath/W/file width (8..16); literal k = ir[7:0] zero-extended
// PC_W        11  program counter / ROM address width; GOTO target = ir[PC_W-1:0] (PC_W<=11)
// RF_ADDR_W   7   file-register address bits; ir[6:0] truncated to RF_ADDR_W
// PORTS
// clk         in   1          clock, all state on posedge
// rst         in   1          synchronous, active-high reset
// halt        in   1          1 = finish current instruction, then stall in S_IDLE
// rom_addr    out  PC_W       program ROM address (registered MAR)
// rom_data    in   14         ROM word, combinational w.r.t. rom_addr
// w_q         out  DATA_W     working register
// status_z    out  1          zero flag
// status_c    out  1          carry / not-borrow flag
// pc_q        out  PC_W       program counter
// instr_done  out  1          1-cycle pulse in the cycle after an instruction retires
// BEHAVIOUR
// - rst (clk=posedge, rst=1): pc_q, rom_addr, ir, w_q, status_z, status_c, instr_done = 0; state = S_IDLE. Register file contents NOT reset.
// - Reset mid-instruction aborts it: no W/file/flag write that cycle; rst wins over all.
// - FSM: S_IDLE -> S_FETCH (halt=0) | stay (halt=1); S_FETCH: rom_addr<=pc; S_INCPC: pc<=pc+1;
//   S_DECODE: ir<=rom_data; S_EXEC: execute, commit, then -> S_FETCH if halt=0 else S_IDLE.
// - 4 cycles per instruction; instr_done asserted the cycle after S_EXEC.
// - Literal ops (ir[13:8]): 110000 MOVLW W=k; 111110 ADDLW W=k+W (Z,C); 111100 SUBLW W=k-W (Z,C);
//   111001 ANDLW, 111000 IORLW, 111010 XORLW (Z only).
// - GOTO 101xxx: pc<=ir[PC_W-1:0] in S_EXEC (overrides S_INCPC value); flags untouched.
// - File ops 00oooo d fffffff, d=ir[7] (0 -> W, 1 -> f): 0111 ADDWF f+W (Z,C); 0010 SUBWF f-W (Z,C);
//   0101 ANDWF, 0100 IORWF, 0110 XORWF, 1000 MOVF, 1010 INCF, 0011 DECF (Z); 0001 d=1 CLRF f=0 Z=1;
//   0000 d=1 MOVWF f=W (no flags); 1011 DECFSZ, 1111 INCFSZ: write result, no flags, skip if result==0.
// - Skip: pc<=pc+1 in S_EXEC (next instruction fetched from pc+2 of original).
// - Carry: C = carry-out bit DATA_W of (DATA_W+1)-bit add; subtract as a + ~b + 1, C=1 means no borrow.
// - Z = (result[DATA_W-1:0]==0). Any other encoding = NOP (4 cycles, nothing changes but pc).
// - PC wraps 2^PC_W-1 -> 0 on increment and on skip.
// - File read is combinational from ir address during S_EXEC; write commits at end of S_EXEC.
// - halt sampled only in S_IDLE and S_EXEC; asserting mid-instruction never truncates it.
// STRUCTURE
// - pic_lite_pkg: state_e {S_IDLE,S_FETCH,S_INCPC,S_DECODE,S_EXEC}; opcode localparams (6-bit literal,
//   4-bit file); decoded op enum; alu_res_t struct {value, z, c, z_en, c_en}.
// - Sub-module pic_lite_regfile: 2^RF_ADDR_W x DATA_W, 1 async read port, 1 sync write port, no reset.
// - ALU as a function in pic_lite_pkg; FSM, PC/MAR/IR/W/STATUS in pic_lite_core.
// TESTING
// - Reset then MOVLW 0x5A; ADDLW 0xB0 -> w_q=0x0A, C=1, Z=0; instr_done pulses every 4 cycles.
// - MOVLW 0x03; SUBLW 0x03 -> w_q=0x00, Z=1, C=1; SUBLW 0x02 with W=3 -> w_q=0xFF, C=0.
// - MOVLW 0x02; MOVWF 0x20; DECFSZ 0x20,1; GOTO 2; MOVLW 0x77 -> loop runs twice, f[0x20]=0, w_q=0x77.
// - CLRF 0x10; INCF 0x10,0 -> w_q=0x01, f[0x10]=0, Z=0; unknown 0x3FFF-class encoding acts as NOP.
// - halt=1 raised during S_DECODE -> instruction completes, then core idles; pc_q frozen; halt=0 resumes.
// - rst asserted in S_EXEC of ADDWF -> no W/f write; pc_q=0; f contents from before preserved.

Source files
------------

// File: rtl/pic_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_lite_pkg
// Description : Shared types, opcode constants, instruction decoder and ALU
//               for the pic_lite accumulator core.
//               The ALU is written for any data width up to 16 bits. The live
//               width is passed in as an argument, and unused upper bits are
//               masked off.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_lite_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_INCPC  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4
    } state_e;

    // Literal-class opcodes, ir[13:8]
    localparam logic [5:0] c_lit_movlw = 6'b110000;
    localparam logic [5:0] c_lit_addlw = 6'b111110;
    localparam logic [5:0] c_lit_sublw = 6'b111100;
    localparam logic [5:0] c_lit_andlw = 6'b111001;
    localparam logic [5:0] c_lit_iorlw = 6'b111000;
    localparam logic [5:0] c_lit_xorlw = 6'b111010;

    // File-class opcodes, ir[11:8] with ir[13:12] == 2'b00
    localparam logic [3:0] c_fop_movwf  = 4'b0000;
    localparam logic [3:0] c_fop_clrf   = 4'b0001;
    localparam logic [3:0] c_fop_subwf  = 4'b0010;
    localparam logic [3:0] c_fop_decf   = 4'b0011;
    localparam logic [3:0] c_fop_iorwf  = 4'b0100;
    localparam logic [3:0] c_fop_andwf  = 4'b0101;
    localparam logic [3:0] c_fop_xorwf  = 4'b0110;
    localparam logic [3:0] c_fop_addwf  = 4'b0111;
    localparam logic [3:0] c_fop_movf   = 4'b1000;
    localparam logic [3:0] c_fop_incf   = 4'b1010;
    localparam logic [3:0] c_fop_decfsz = 4'b1011;
    localparam logic [3:0] c_fop_incfsz = 4'b1111;

    typedef enum logic [4:0] {
        OP_NOP, OP_GOTO,
        OP_MOVLW, OP_ADDLW, OP_SUBLW, OP_ANDLW, OP_IORLW, OP_XORLW,
        OP_ADDWF, OP_SUBWF, OP_ANDWF, OP_IORWF, OP_XORWF, OP_MOVF,
        OP_INCF, OP_DECF, OP_CLRF, OP_MOVWF, OP_DECFSZ, OP_INCFSZ
    } op_e;

    typedef struct packed {
        logic [15:0] value;
        logic        z;
        logic        c;
        logic        z_en;
        logic        c_en;
    } alu_res_t;

    function automatic op_e decode(input logic [13:0] ir);
        op_e op;
        op = OP_NOP;
        if (ir[13:11] == 3'b101) begin
            op = OP_GOTO;
        end else if (ir[13:12] == 2'b11) begin
            case (ir[13:8])
                c_lit_movlw: op = OP_MOVLW;
                c_lit_addlw: op = OP_ADDLW;
                c_lit_sublw: op = OP_SUBLW;
                c_lit_andlw: op = OP_ANDLW;
                c_lit_iorlw: op = OP_IORLW;
                c_lit_xorlw: op = OP_XORLW;
                default:     op = OP_NOP;
            endcase
        end else if (ir[13:12] == 2'b00) begin
            case (ir[11:8])
                c_fop_addwf:  op = OP_ADDWF;
                c_fop_subwf:  op = OP_SUBWF;
                c_fop_andwf:  op = OP_ANDWF;
                c_fop_iorwf:  op = OP_IORWF;
                c_fop_xorwf:  op = OP_XORWF;
                c_fop_movf:   op = OP_MOVF;
                c_fop_incf:   op = OP_INCF;
                c_fop_decf:   op = OP_DECF;
                c_fop_decfsz: op = OP_DECFSZ;
                c_fop_incfsz: op = OP_INCFSZ;
                // CLRF/MOVWF only exist with the file destination.
                c_fop_clrf:   op = ir[7] ? OP_CLRF  : OP_NOP;
                c_fop_movwf:  op = ir[7] ? OP_MOVWF : OP_NOP;
                default:      op = OP_NOP;
            endcase
        end
        return op;
    endfunction

    function automatic logic is_file_op(input op_e op);
        return (op inside {OP_ADDWF, OP_SUBWF, OP_ANDWF, OP_IORWF, OP_XORWF,
                           OP_MOVF, OP_INCF, OP_DECF, OP_CLRF, OP_MOVWF,
                           OP_DECFSZ, OP_INCFSZ});
    endfunction

    // a = literal or file operand, w = working register, dw = live data width.
    // Sums are computed one bit wider than dw, and carry is read from bit dw.
    // A subtraction is computed as a + ~w + 1, so that C=1 means no borrow.
    function automatic alu_res_t alu(input op_e op, input logic [15:0] a,
                                     input logic [15:0] w, input int unsigned dw);
        alu_res_t    res;
        logic [16:0] mask;
        logic [16:0] a_x;
        logic [16:0] w_x;
        logic [16:0] sum;
        logic [16:0] shifted;
        res  = '0;
        mask = (17'd1 << dw) - 17'd1;
        a_x  = {1'b0, a} & mask;
        w_x  = {1'b0, w} & mask;
        sum  = 17'd0;
        case (op)
            OP_MOVLW:             sum = a_x;
            OP_MOVF:              begin sum = a_x; res.z_en = 1'b1; end
            OP_MOVWF:             sum = w_x;
            OP_ADDLW, OP_ADDWF:   begin
                sum = a_x + w_x;
                res.z_en = 1'b1; res.c_en = 1'b1;
            end
            OP_SUBLW, OP_SUBWF:   begin
                sum = a_x + (~w_x & mask) + 17'd1;
                res.z_en = 1'b1; res.c_en = 1'b1;
            end
            OP_ANDLW, OP_ANDWF:   begin sum = a_x & w_x; res.z_en = 1'b1; end
            OP_IORLW, OP_IORWF:   begin sum = a_x | w_x; res.z_en = 1'b1; end
            OP_XORLW, OP_XORWF:   begin sum = a_x ^ w_x; res.z_en = 1'b1; end
            OP_INCF, OP_INCFSZ:   begin sum = a_x + 17'd1; res.z_en = (op == OP_INCF); end
            // Adding all-ones within the mask decrements modulo 2^dw.
            OP_DECF, OP_DECFSZ:   begin sum = a_x + mask;  res.z_en = (op == OP_DECF); end
            OP_CLRF:              begin sum = 17'd0; res.z_en = 1'b1; end
            default:              sum = 17'd0;
        endcase
        shifted   = sum >> dw;
        res.c     = shifted[0];
        res.value = sum[15:0] & mask[15:0];
        res.z     = (res.value == 16'd0);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pic_lite_regfile
// Description : Data register file with 2^ADDR_W words of DATA_W bits.
//               It has one asynchronous read port and one synchronous write
//               port. The contents are not reset.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address
//               o_rdata  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module pic_lite_regfile
    import pic_lite_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pic_lite_core.sv
`default_nettype none
// ============================================================================
// Module      : pic_lite_core
// Description : Accumulator CPU core that runs a 14-bit PIC-style subset.
//               Each instruction takes four cycles: FETCH, INCPC, DECODE and
//               EXEC. An IDLE state is used for reset and halt.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               halt                 - stop after the current instruction
//               rom_addr / rom_data  - asynchronous program ROM interface
//               w_q, status_z/c      - working register and flags
//               pc_q                 - program counter
//               instr_done           - pulse in the cycle after retirement
// Revision    : 1.0 - initial release
// ============================================================================
module pic_lite_core
    import pic_lite_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 11,
    parameter int RF_ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [13:0]       rom_data,
    output logic [DATA_W-1:0] w_q,
    output logic              status_z,
    output logic              status_c,
    output logic [PC_W-1:0]   pc_q,
    output logic              instr_done
);

    localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);

    state_e            r_state;
    state_e            w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_mar;
    logic [13:0]       r_ir;
    logic [DATA_W-1:0] r_w;
    logic              r_z;
    logic              r_c;
    logic              r_done;

    op_e               w_op;
    logic              w_is_file;
    logic              w_exec;
    logic              w_wr_f;
    logic              w_wr_w;
    logic              w_skip;
    logic [DATA_W-1:0] w_f_rd;
    logic [15:0]       w_operand;
    alu_res_t          w_alu;
    logic [DATA_W-1:0] w_result;
    logic              w_unused;

    assign w_op      = decode(r_ir);
    assign w_is_file = is_file_op(w_op);
    assign w_exec    = (r_state == S_EXEC);
    assign w_operand = w_is_file ? 16'(w_f_rd) : {8'd0, r_ir[7:0]};
    assign w_alu     = alu(w_op, w_operand, 16'(r_w), DATA_W);
    assign w_result  = w_alu.value[DATA_W-1:0];
    assign w_unused  = ^w_alu.value;

    // The d bit selects the destination for file ops. Literal ops always
    // write W. GOTO and NOP write nothing.
    assign w_wr_f = w_exec && w_is_file && r_ir[7];
    assign w_wr_w = w_exec && (w_op != OP_NOP) && (w_op != OP_GOTO)
                    && !(w_is_file && r_ir[7]);
    assign w_skip = (w_op == OP_DECFSZ || w_op == OP_INCFSZ) && w_alu.z;

    // The write enable is gated with rst, so a reset during EXEC aborts the
    // file write.
    pic_lite_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (RF_ADDR_W)
    ) u_rf (
        .clk     (clk),
        .i_we    (w_wr_f && !rst),
        .i_waddr (r_ir[RF_ADDR_W-1:0]),
        .i_wdata (w_result),
        .i_raddr (r_ir[RF_ADDR_W-1:0]),
        .o_rdata (w_f_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = halt ? S_IDLE : S_FETCH;
            S_FETCH:  w_next_state = S_INCPC;
            S_INCPC:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC:   w_next_state = halt ? S_IDLE : S_FETCH;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_mar  <= '0;
            r_ir   <= '0;
            r_w    <= '0;
            r_z    <= 1'b0;
            r_c    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_exec;
            case (r_state)
                S_FETCH:  r_mar <= r_pc;
                S_INCPC:  r_pc  <= r_pc + c_pc_one;
                S_DECODE: r_ir  <= rom_data;
                S_EXEC: begin
                    // pc already points past this instruction. GOTO replaces
                    // it, and a skip advances it once more. Both wrap.
                    if (w_op == OP_GOTO) begin
                        r_pc <= r_ir[PC_W-1:0];
                    end else if (w_skip) begin
                        r_pc <= r_pc + c_pc_one;
                    end
                    if (w_wr_w) begin
                        r_w <= w_result;
                    end
                    if (w_alu.z_en) begin
                        r_z <= w_alu.z;
                    end
                    if (w_alu.c_en) begin
                        r_c <= w_alu.c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr   = r_mar;
    assign pc_q       = r_pc;
    assign w_q        = r_w;
    assign status_z   = r_z;
    assign status_c   = r_c;
    assign instr_done = r_done;

endmodule
`default_nettype wire
